// File: rtl/pc_gen_pkg.sv
// ============================================================================
// pc_gen_pkg : shared EX redirect-select encodings for the fetch PC generator
// Rev 1.0
// ============================================================================
`default_nettype none

package pc_gen_pkg;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_NT_T = 2'b01;
  localparam logic [1:0] SEL_JUMP = 2'b10;
  localparam logic [1:0] SEL_T_NT = 2'b11;

endpackage : pc_gen_pkg

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
// ras_stack : circular return-address stack with saturating count, zero-latency top
// Rev 1.0
// ============================================================================
`default_nettype none

module ras_stack
  import pc_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            overflow_o
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx, wr_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d, wr_en;

  // ptr_q names the next free slot, so the top lives one below it
  assign top_idx    = ptr_q - PW'(1);
  assign top_o      = mem_q[top_idx];
  assign empty_o    = (cnt_q == '0);
  assign overflow_o = ovf_q;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && (!pop_i || empty_o)) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + (PW+1)'(1);
    end else if (push_i && pop_i) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule : ras_stack

`default_nettype wire

// File: rtl/pc_gen_if_stage.sv
// ============================================================================
// pc_gen_if_stage : fetch PC register and prioritised next-PC selection
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_gen_if_stage
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_IF,
  input  logic [1:0]      PC_adder_mux_select,
  input  logic            jump_flag_EX_in,
  input  logic [XLEN-1:0] PC_plus_offset_from_EX,
  input  logic [XLEN-1:0] ALU_out,
  input  logic [XLEN-1:0] PC_EX,
  input  logic            pred_taken_IF,
  input  logic [XLEN-1:0] pred_target_IF,
  input  logic            call_IF,
  input  logic            ret_IF,
  output logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PC_next,
  output logic            redirect_EX,
  output logic            illegal_sel,
  output logic            ras_empty,
  output logic            ras_overflow
);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4, ras_top;
  logic            advance;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign advance  = !stall_IF && !redirect_EX;
  assign PC_out   = pc_q;
  assign PC_next  = pc_d;

  always_comb begin
    pc_d        = pc_plus4;
    redirect_EX = 1'b0;
    illegal_sel = 1'b0;
    case (PC_adder_mux_select)
      SEL_NT_T: begin
        pc_d        = PC_plus_offset_from_EX;
        redirect_EX = 1'b1;
      end
      SEL_JUMP: begin
        if (jump_flag_EX_in) begin
          pc_d        = ALU_out & ~XLEN'(1);
          redirect_EX = 1'b1;
        end else begin
          illegal_sel = 1'b1;
        end
      end
      SEL_T_NT: begin
        pc_d        = PC_EX + XLEN'(4);
        redirect_EX = 1'b1;
      end
      default: ;
    endcase
    if (!redirect_EX) begin
      if (ret_IF && !ras_empty) pc_d = ras_top;
      else if (pred_taken_IF)   pc_d = pred_target_IF;
    end
  end

  // EX redirects must land even while fetch is stalled
  always_ff @(posedge clk) begin
    if (reset)                        pc_q <= RESET_VECTOR;
    else if (!stall_IF || redirect_EX) pc_q <= pc_d;
  end

  ras_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .push_i     (advance && call_IF),
    .pop_i      (advance && ret_IF),
    .data_i     (pc_plus4),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .overflow_o (ras_overflow)
  );

endmodule : pc_gen_if_stage

`default_nettype wire

// File: tb/tb_pc_gen_if_stage.sv
// ============================================================================
// tb_pc_gen_if_stage : directed scoreboard bench for pc_gen_if_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_gen_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall_IF, jump_flag_EX_in, pred_taken_IF, call_IF, ret_IF;
  logic [1:0]  sel;
  logic [31:0] off_ex, alu_out, pc_ex, pred_tgt;
  logic [31:0] PC_out, PC_next;
  logic        redirect_EX, illegal_sel, ras_empty, ras_overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  pc_gen_if_stage #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .RAS_DEPTH    (4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .stall_IF               (stall_IF),
    .PC_adder_mux_select    (sel),
    .jump_flag_EX_in        (jump_flag_EX_in),
    .PC_plus_offset_from_EX (off_ex),
    .ALU_out                (alu_out),
    .PC_EX                  (pc_ex),
    .pred_taken_IF          (pred_taken_IF),
    .pred_target_IF         (pred_tgt),
    .call_IF                (call_IF),
    .ret_IF                 (ret_IF),
    .PC_out                 (PC_out),
    .PC_next                (PC_next),
    .redirect_EX            (redirect_EX),
    .illegal_sel            (illegal_sel),
    .ras_empty              (ras_empty),
    .ras_overflow           (ras_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] pc);
    exp_t e;
    e.tag = tag;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  // advance one clock and retire one scoreboard entry against PC_out
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, PC_out, e.pc);
    end
  endtask

  task automatic idle_inputs();
    stall_IF = 0; sel = 2'b00; jump_flag_EX_in = 0;
    off_ex = '0; alu_out = '0; pc_ex = '0;
    pred_taken_IF = 0; pred_tgt = '0; call_IF = 0; ret_IF = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rets [4];
    rets[0] = 32'h54; rets[1] = 32'h44; rets[2] = 32'h34; rets[3] = 32'h24;

    idle_inputs();
    reset = 1;
    tick();
    expect_pc("reset_pc", 32'h100);
    tick();
    chk("reset_empty", {31'b0, ras_empty}, 32'd1);
    chk("reset_ovf", {31'b0, ras_overflow}, 32'd0);
    reset = 0;

    expect_pc("seq0", 32'h104); tick();
    expect_pc("seq1", 32'h108); tick();
    expect_pc("seq2", 32'h10C); tick();
    #1 chk("seq_next", PC_next, 32'h110);

    // EX redirect overrides stall
    sel = 2'b01; off_ex = 32'h200;
    #1 chk("nt_t_redir", {31'b0, redirect_EX}, 32'd1);
    expect_pc("nt_t_pc", 32'h200); tick();
    sel = 2'b00; stall_IF = 1;
    expect_pc("stall_hold", 32'h200); tick();
    sel = 2'b11; pc_ex = 32'h40;
    #1 chk("t_nt_redir", {31'b0, redirect_EX}, 32'd1);
    chk("t_nt_next", PC_next, 32'h44);
    expect_pc("t_nt_pc", 32'h44); tick();
    idle_inputs();

    // jump code with and without qualifier
    sel = 2'b10; jump_flag_EX_in = 0; alu_out = 32'h301;
    #1 chk("illegal_sel", {31'b0, illegal_sel}, 32'd1);
    chk("illegal_noredir", {31'b0, redirect_EX}, 32'd0);
    expect_pc("illegal_pc", 32'h48); tick();
    jump_flag_EX_in = 1;
    #1 chk("jump_legal", {31'b0, illegal_sel}, 32'd0);
    expect_pc("jump_pc", 32'h300); tick();
    idle_inputs();

    // five calls into a four-deep stack
    sel = 2'b01; off_ex = 32'h10;
    expect_pc("to_0x10", 32'h10); tick();
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      call_IF = 1; pred_taken_IF = 1; pred_tgt = 32'h10 * (k + 1);
      expect_pc("call_pc", 32'h10 * (k + 1)); tick();
    end
    idle_inputs();
    chk("ovf_set", {31'b0, ras_overflow}, 32'd1);
    chk("full_nonempty", {31'b0, ras_empty}, 32'd0);
    ret_IF = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("ret_next", PC_next, rets[k]);
      expect_pc("ret_pc", rets[k]); tick();
    end
    chk("ret_empty", {31'b0, ras_empty}, 32'd1);
    pred_taken_IF = 1; pred_tgt = 32'h700;
    #1 chk("ret_empty_pred", PC_next, 32'h700);
    expect_pc("ret_pred_pc", 32'h700); tick();
    pred_taken_IF = 0;
    expect_pc("ret_seq_pc", 32'h704); tick();
    idle_inputs();

    // return alongside an EX redirect must not pop
    call_IF = 1;
    expect_pc("call2_pc", 32'h708); tick();
    call_IF = 0; ret_IF = 1; sel = 2'b01; off_ex = 32'h900;
    #1 chk("ret_redir_next", PC_next, 32'h900);
    expect_pc("ret_redir_pc", 32'h900); tick();
    sel = 2'b00;
    #1 chk("ret_kept_next", PC_next, 32'h708);
    expect_pc("ret_kept_pc", 32'h708); tick();
    chk("ret_kept_empty", {31'b0, ras_empty}, 32'd1);
    idle_inputs();

    // call+return replaces the top entry
    call_IF = 1;
    expect_pc("call3_pc", 32'h70C); tick();
    ret_IF = 1;
    #1 chk("replace_next", PC_next, 32'h70C);
    expect_pc("replace_pc", 32'h70C); tick();
    call_IF = 0;
    #1 chk("replace_top", PC_next, 32'h710);
    expect_pc("replace_ret", 32'h710); tick();
    chk("replace_empty", {31'b0, ras_empty}, 32'd1);
    idle_inputs();

    // modulo wrap of the sequential increment
    sel = 2'b01; off_ex = 32'hFFFF_FFFC;
    expect_pc("to_top", 32'hFFFF_FFFC); tick();
    sel = 2'b00;
    #1 chk("wrap_next", PC_next, 32'h0);
    expect_pc("wrap_pc", 32'h0); tick();

    // reset mid-operation discards the stack
    call_IF = 1;
    expect_pc("call4_pc", 32'h4); tick();
    chk("pre_rst_nonempty", {31'b0, ras_empty}, 32'd0);
    reset = 1;
    expect_pc("midrst_pc", 32'h100); tick();
    chk("midrst_empty", {31'b0, ras_empty}, 32'd1);
    reset = 0;
    idle_inputs();

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pc_gen_if_stage

`default_nettype wire
